// File: rtl/otter_bus_xbar_pkg.sv
// otter_bus_xbar_pkg: shared definitions for the Otter data-bus crossbar.
//   - xbar_state_e : transaction FSM encodings (IDLE / BUSY / RESP)
//   - BusOk/BusErr : values carried on o_m_err
//   - idx_width()  : width of a binary slave index
//   - tmo_width()  : width of the optional hung-slave counter (8..16 bits)
//   - mask_wdata() : clears write-data bytes whose byte enable is low
package otter_bus_xbar_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } xbar_state_e;

    localparam logic BusOk  = 1'b0;
    localparam logic BusErr = 1'b1;

    localparam int unsigned TmoMinW = 8;
    localparam int unsigned TmoMaxW = 16;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned tmo_width(input int unsigned limit);
        int unsigned w;
        w = $clog2(limit + 1);
        if (w < TmoMinW) w = TmoMinW;
        if (w > TmoMaxW) w = TmoMaxW;
        return w;
    endfunction

    function automatic logic [31:0] mask_wdata(input logic [31:0] data,
                                               input logic [3:0]  sel,
                                               input bit          zero_unsel);
        logic [31:0] res;
        res = data;
        for (int b = 0; b < 4; b++) begin
            if (zero_unsel && !sel[b]) res[8*b +: 8] = 8'h00;
        end
        return res;
    endfunction

endpackage

// File: rtl/otter_bus_xbar_addr_decode.sv
// otter_addr_decode: combinational priority address decoder.
// Slave i hits when (addr_i & MASK_i) == BASE_i; the lowest index wins on overlap.
// Ports:
//   addr_i : byte address from the master
//   hit_o  : some slave window matched
//   sel_o  : one-hot select of the winning slave (all zero on a miss)
//   idx_o  : binary index of the winning slave (zero on a miss)
module otter_addr_decode
    import otter_bus_xbar_pkg::*;
#(
    parameter int unsigned                  NUM_SLAVES = 2,
    parameter logic [32*NUM_SLAVES-1:0]     SLAVE_BASE = {32'h0000_0000, 32'h8000_0000},
    parameter logic [32*NUM_SLAVES-1:0]     SLAVE_MASK = {32'h8000_0000, 32'h8000_0000}
) (
    input  logic [31:0]                        addr_i,
    output logic                               hit_o,
    output logic [NUM_SLAVES-1:0]              sel_o,
    output logic [idx_width(NUM_SLAVES)-1:0]   idx_o
);

    localparam int unsigned IdxW = idx_width(NUM_SLAVES);

    // Scan from the highest index down so the lowest matching index is the last writer.
    always_comb begin
        hit_o = 1'b0;
        sel_o = '0;
        idx_o = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr_i & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit_o    = 1'b1;
                sel_o    = '0;
                sel_o[i] = 1'b1;
                idx_o    = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/otter_bus_xbar.sv
// otter_bus_xbar: data-bus decoder between the hart dmem port and NUM_SLAVES targets.
// One transaction outstanding at a time; request/ack handshake with registered outputs.
// Optional feature macro: OTTER_BUS_TIMEOUT_EN (hung-slave timeout, TIMEOUT_CYCLES limit).
// Ports:
//   i_clk, i_rst                  : clock, asynchronous active-high reset
//   i_m_re/i_m_we/i_m_sel/i_m_addr/i_m_w_data : master request (re+we counts as write)
//   o_m_r_data/o_m_ack/o_m_err    : one-cycle response; r_data and err qualified by ack
//   o_s_cyc                       : one-hot slave select, high only in BUSY
//   o_s_we/o_s_sel/o_s_addr/o_s_w_data : latched request broadcast to all slaves
//   i_s_r_data/i_s_ack            : per-slave read data and completion
module otter_bus_xbar
    import otter_bus_xbar_pkg::*;
#(
    parameter int unsigned                  NUM_SLAVES       = 2,
    parameter logic [32*NUM_SLAVES-1:0]     SLAVE_BASE       = {32'h0000_0000, 32'h8000_0000},
    parameter logic [32*NUM_SLAVES-1:0]     SLAVE_MASK       = {32'h8000_0000, 32'h8000_0000},
    parameter int unsigned                  TIMEOUT_CYCLES   = 255,
    parameter int unsigned                  ZERO_UNSEL_BYTES = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_m_re,
    input  logic                       i_m_we,
    input  logic [3:0]                 i_m_sel,
    input  logic [31:0]                i_m_addr,
    input  logic [31:0]                i_m_w_data,
    output logic [31:0]                o_m_r_data,
    output logic                       o_m_ack,
    output logic                       o_m_err,
    output logic [NUM_SLAVES-1:0]      o_s_cyc,
    output logic                       o_s_we,
    output logic [3:0]                 o_s_sel,
    output logic [31:0]                o_s_addr,
    output logic [31:0]                o_s_w_data,
    input  logic [32*NUM_SLAVES-1:0]   i_s_r_data,
    input  logic [NUM_SLAVES-1:0]      i_s_ack
);

    localparam int unsigned IdxW = idx_width(NUM_SLAVES);

    if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
    begin : g_bad_cfg
        $error("otter_bus_xbar: NUM_SLAVES must be 1..8 and TIMEOUT_CYCLES 1..65535");
    end

    xbar_state_e state_q, state_d;

    logic [NUM_SLAVES-1:0] cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic [3:0]            sel_q, sel_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;

    logic                  dec_hit;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic [IdxW-1:0]       dec_idx;

    logic [31:0]           s_rdata [NUM_SLAVES];
    logic                  slv_ack;
    logic [31:0]           slv_rdata;
    logic                  m_req;
    logic                  tmo_hit;

    otter_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .addr_i (i_m_addr),
        .hit_o  (dec_hit),
        .sel_o  (dec_sel),
        .idx_o  (dec_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
            s_rdata[i] = i_s_r_data[32*i +: 32];
        end
    end

    assign m_req     = i_m_re | i_m_we;
    // Only the latched slave's ack counts; everything else on i_s_ack is ignored.
    assign slv_ack   = i_s_ack[idx_q];
    assign slv_rdata = s_rdata[idx_q];

`ifdef OTTER_BUS_TIMEOUT_EN
    localparam int unsigned     TmoW    = tmo_width(TIMEOUT_CYCLES);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    logic [TmoW-1:0] tmo_q, tmo_d;

    // Held at zero outside BUSY, so it is already clear on entry.
    always_comb begin
        tmo_d = '0;
        if (state_q == StBusy) tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end

    // Fires in the TIMEOUT_CYCLES-th BUSY cycle; a same-cycle ack takes priority below.
    assign tmo_hit = (state_q == StBusy) && (tmo_q == TmoLast);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        ack_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                cyc_d = '0;
                if (m_req) begin
                    if (dec_hit) begin
                        state_d = StBusy;
                        cyc_d   = dec_sel;
                        we_d    = i_m_we;
                        sel_d   = i_m_sel;
                        addr_d  = i_m_addr;
                        wdata_d = mask_wdata(i_m_w_data, i_m_sel, ZERO_UNSEL_BYTES != 0);
                        idx_d   = dec_idx;
                    end else begin
                        state_d = StResp;
                        ack_d   = 1'b1;
                        err_d   = BusErr;
                        rdata_d = '0;
                    end
                end
            end
            StBusy: begin
                if (slv_ack) begin
                    state_d = StResp;
                    cyc_d   = '0;
                    ack_d   = 1'b1;
                    err_d   = BusOk;
                    rdata_d = we_q ? '0 : slv_rdata;
                end else if (tmo_hit) begin
                    state_d = StResp;
                    cyc_d   = '0;
                    ack_d   = 1'b1;
                    err_d   = BusErr;
                    rdata_d = '0;
                end
            end
            StResp: begin
                state_d = StIdle;
                err_d   = BusOk;
                rdata_d = '0;
            end
            default: begin
                state_d = StIdle;
                cyc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            cyc_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign o_s_cyc    = cyc_q;
    assign o_s_we     = we_q;
    assign o_s_sel    = sel_q;
    assign o_s_addr   = addr_q;
    assign o_s_w_data = wdata_q;
    assign o_m_ack    = ack_q;
    assign o_m_err    = err_q;
    assign o_m_r_data = rdata_q;

endmodule

// File: tb/tb_otter_bus_xbar.sv
// Bench for otter_bus_xbar: DUT A uses default windows, DUT B uses
// slave0 = 0x1100_0000/0xFF00_0000, slave1 = 0x8000_0000/0x8000_0000, TIMEOUT_CYCLES = 4.
module tb_otter_bus_xbar;

`ifdef OTTER_BUS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Bench-side master / slave stimulus, steered to one DUT at a time.
    bit          tgt = 1'b0;
    logic        m_re = 1'b0, m_we = 1'b0;
    logic [3:0]  m_sel = '0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [1:0]  s_ack = '0;
    logic [63:0] s_rdata = '0;

    logic [31:0] a_m_r_data, b_m_r_data;
    logic        a_m_ack, b_m_ack, a_m_err, b_m_err;
    logic [1:0]  a_s_cyc, b_s_cyc;
    logic        a_s_we, b_s_we;
    logic [3:0]  a_s_sel, b_s_sel;
    logic [31:0] a_s_addr, b_s_addr, a_s_w_data, b_s_w_data;

    logic [31:0] ob_m_r_data, ob_s_addr, ob_s_w_data;
    logic        ob_m_ack, ob_m_err, ob_s_we;
    logic [1:0]  ob_s_cyc;
    logic [3:0]  ob_s_sel;

    assign ob_m_r_data = tgt ? b_m_r_data : a_m_r_data;
    assign ob_m_ack    = tgt ? b_m_ack    : a_m_ack;
    assign ob_m_err    = tgt ? b_m_err    : a_m_err;
    assign ob_s_cyc    = tgt ? b_s_cyc    : a_s_cyc;
    assign ob_s_we     = tgt ? b_s_we     : a_s_we;
    assign ob_s_sel    = tgt ? b_s_sel    : a_s_sel;
    assign ob_s_addr   = tgt ? b_s_addr   : a_s_addr;
    assign ob_s_w_data = tgt ? b_s_w_data : a_s_w_data;

    otter_bus_xbar u_dut_a (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_m_re     (m_re & ~tgt),
        .i_m_we     (m_we & ~tgt),
        .i_m_sel    (m_sel),
        .i_m_addr   (m_addr),
        .i_m_w_data (m_wdata),
        .o_m_r_data (a_m_r_data),
        .o_m_ack    (a_m_ack),
        .o_m_err    (a_m_err),
        .o_s_cyc    (a_s_cyc),
        .o_s_we     (a_s_we),
        .o_s_sel    (a_s_sel),
        .o_s_addr   (a_s_addr),
        .o_s_w_data (a_s_w_data),
        .i_s_r_data (s_rdata),
        .i_s_ack    (tgt ? 2'b00 : s_ack)
    );

    otter_bus_xbar #(
        .NUM_SLAVES     (2),
        .SLAVE_BASE     ({32'h8000_0000, 32'h1100_0000}),
        .SLAVE_MASK     ({32'h8000_0000, 32'hFF00_0000}),
        .TIMEOUT_CYCLES (4)
    ) u_dut_b (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_m_re     (m_re & tgt),
        .i_m_we     (m_we & tgt),
        .i_m_sel    (m_sel),
        .i_m_addr   (m_addr),
        .i_m_w_data (m_wdata),
        .o_m_r_data (b_m_r_data),
        .o_m_ack    (b_m_ack),
        .o_m_err    (b_m_err),
        .o_s_cyc    (b_s_cyc),
        .o_s_we     (b_s_we),
        .o_s_sel    (b_s_sel),
        .o_s_addr   (b_s_addr),
        .o_s_w_data (b_s_w_data),
        .i_s_r_data (s_rdata),
        .i_s_ack    (tgt ? s_ack : 2'b00)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Address map as a plain lookup table: first matching window wins, -1 on miss.
    function automatic int model_slave(input bit b, input logic [31:0] a);
        logic [31:0] base [2];
        logic [31:0] mask [2];
        if (!b) begin
            base[0] = 32'h8000_0000; mask[0] = 32'h8000_0000;
            base[1] = 32'h0000_0000; mask[1] = 32'h8000_0000;
        end else begin
            base[0] = 32'h1100_0000; mask[0] = 32'hFF00_0000;
            base[1] = 32'h8000_0000; mask[1] = 32'h8000_0000;
        end
        for (int i = 0; i < 2; i++) begin
            if ((a & mask[i]) == base[i]) return i;
        end
        return -1;
    endfunction

    // One full transaction. delay = BUSY cycles the slave waits before acking;
    // spur = the other slave acks throughout BUSY. Latency counted in edges from request.
    task automatic run_txn(input bit b, input logic re, input logic we, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int delay, input logic [31:0] sdata, input bit spur);
        int          hit, exp_busy, busy, tmo;
        bit          exp_err, done;
        logic [31:0] exp_wd, exp_rd;
        tgt = b;
        hit = model_slave(b, addr);
        for (int k = 0; k < 4; k++) exp_wd[8*k +: 8] = sel[k] ? wdata[8*k +: 8] : 8'h00;
        tmo = b ? 4 : 255;
        if (hit < 0) begin
            exp_busy = 0; exp_err = 1'b1; exp_rd = '0;
        end else if (TMO_EN && delay >= tmo) begin
            exp_busy = tmo; exp_err = 1'b1; exp_rd = '0;
        end else begin
            exp_busy = delay + 1; exp_err = 1'b0; exp_rd = (re && !we) ? sdata : 32'h0;
        end
        m_re = re; m_we = we; m_sel = sel; m_addr = addr; m_wdata = wdata;
        busy = 0;
        done = 1'b0;
        for (int n = 1; n <= 300 && !done; n++) begin
            @(posedge clk); #1;
            s_ack   = '0;
            s_rdata = {$urandom, $urandom};
            if (ob_s_cyc != 2'b00) begin
                if (busy == 0) begin
                    check("s_cyc",    ob_s_cyc,    (hit >= 0) ? (2'b01 << hit) : 2'b00);
                    check("s_we",     ob_s_we,     we);
                    check("s_sel",    ob_s_sel,    sel);
                    check("s_addr",   ob_s_addr,   addr);
                    check("s_w_data", ob_s_w_data, exp_wd);
                end
                if (busy == delay && hit >= 0) begin
                    s_ack[hit]            = 1'b1;
                    s_rdata[32*hit +: 32] = sdata;
                end
                if (spur && hit >= 0) s_ack[1-hit] = 1'b1;
                busy++;
            end
            if (ob_m_ack) begin
                done = 1'b1;
                check("latency",    n,           exp_busy + 1);
                check("busy_count", busy,        exp_busy);
                check("m_err",      ob_m_err,    exp_err);
                check("m_r_data",   ob_m_r_data, exp_rd);
            end
        end
        if (!done) check("ack_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        m_re = 1'b0; m_we = 1'b0; s_ack = '0;
        check("ack_pulse", ob_m_ack, 1'b0);
        check("idle_cyc",  ob_s_cyc, 2'b00);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] ra;
        #1 rst = 1'b1;
        #3;
        check("rst_a_cyc",   a_s_cyc,    2'b00);
        check("rst_a_ack",   a_m_ack,    1'b0);
        check("rst_a_err",   a_m_err,    1'b0);
        check("rst_a_rdata", a_m_r_data, 32'h0);
        check("rst_a_bus",   {a_s_we, a_s_sel, a_s_addr, a_s_w_data}, 69'h0);
        check("rst_b_cyc",   b_s_cyc,    2'b00);
        check("rst_b_ack",   b_m_ack,    1'b0);
        @(posedge clk); #1 rst = 1'b0;

        // Default map: read hits slave0, immediate ack -> ack three cycles after request.
        run_txn(1'b0, 1'b1, 1'b0, 4'hF, 32'h8000_0010, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
        // Masked write to slave1, slow ack.
        run_txn(1'b0, 1'b0, 1'b1, 4'b0101, 32'h0000_0040, 32'h1122_3344, 5, 32'hCAFE_F00D, 1'b0);
        // Spurious acks from slave1 while slave0 is busy.
        run_txn(1'b0, 1'b1, 1'b0, 4'hF, 32'h8000_0100, 32'h0, 3, 32'h1234_5678, 1'b1);
        // re and we together behaves as a write.
        run_txn(1'b0, 1'b1, 1'b1, 4'b1010, 32'h0000_0080, 32'hA1B2_C3D4, 1, 32'h5555_AAAA, 1'b0);

        // Map B: unmapped address -> ack+err after two cycles, no cyc.
        run_txn(1'b1, 1'b1, 1'b0, 4'hF, 32'h2000_0000, 32'h0, 0, 32'h0BAD_0BAD, 1'b0);
        run_txn(1'b1, 1'b1, 1'b0, 4'hF, 32'h11AB_0000, 32'h0, 1, 32'h0F0F_1234, 1'b0);
        run_txn(1'b1, 1'b0, 1'b1, 4'hF, 32'h9000_0004, 32'h7766_5544, 0, 32'h0, 1'b0);
`ifdef OTTER_BUS_TIMEOUT_EN
        // Hung slave -> 4 BUSY cycles then err; ack on the limit cycle still wins.
        run_txn(1'b1, 1'b1, 1'b0, 4'hF, 32'h1100_0008, 32'h0, 50, 32'h1111_2222, 1'b0);
        run_txn(1'b1, 1'b1, 1'b0, 4'hF, 32'h1100_000C, 32'h0, 3, 32'h3333_4444, 1'b0);
        run_txn(1'b1, 1'b1, 1'b0, 4'hF, 32'h8800_0000, 32'h0, 0, 32'h5151_5151, 1'b0);
`endif

        // Asynchronous reset in the middle of BUSY.
        tgt = 1'b0;
        m_re = 1'b1; m_we = 1'b0; m_sel = 4'hF; m_addr = 32'h8000_0020;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_cyc", ob_s_cyc, 2'b01);
        #2 rst = 1'b1;
        #1;
        check("async_rst_cyc", ob_s_cyc, 2'b00);
        check("async_rst_ack", ob_m_ack, 1'b0);
        m_re = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        run_txn(1'b0, 1'b1, 1'b0, 4'hF, 32'h8000_0024, 32'h0, 0, 32'h600D_F00D, 1'b0);

        // Randomised traffic on both maps.
        for (int t = 0; t < 40; t++) begin
            op = 2'($urandom_range(1, 3));
            ra = $urandom;
            if (t % 4 == 3) begin
                case ($urandom_range(0, 2))
                    0:       ra = {8'h11, ra[23:0]};
                    1:       ra = {1'b1, ra[30:0]};
                    default: ra = {1'b0, ra[30:0]};
                endcase
                run_txn(1'b1, op[0], op[1], 4'($urandom), ra, $urandom,
                        int'($urandom_range(0, 2)), $urandom, 1'($urandom));
            end else begin
                run_txn(1'b0, op[0], op[1], 4'($urandom), ra, $urandom,
                        int'($urandom_range(0, 4)), $urandom, 1'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
